// File: rtl/reg_native_arb_if.sv
// Native register-bus handshake: one request/ack pair carrying address, data and error.
// Upstream masters see an error flag; the downstream target port has none.
interface reg_native_arb_if #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32
);
  logic                  req_vld;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] addr;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  ack_vld;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  err;

  modport master (
    output req_vld, wr_en, rd_en, addr, wr_data,
    input  ack_vld, rd_data, err
  );

  modport slave (
    input  req_vld, wr_en, rd_en, addr, wr_data,
    output ack_vld, rd_data, err
  );

  // Arbiter-to-target view: no error flag comes back from the target.
  modport dn_master (
    output req_vld, wr_en, rd_en, addr, wr_data,
    input  ack_vld, rd_data
  );
endinterface

// File: rtl/reg_native_arb.sv
// Round-robin arbiter sharing one native register target between two masters,
// one transaction in flight, with an ack timeout that returns an error response.
module reg_native_arb #(
  parameter int ADDR_WIDTH = 64,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 255
) (
  input  logic                fsm_clk,
  input  logic                fsm_rstn,
  reg_native_arb_if.slave     m0_if,
  reg_native_arb_if.slave     m1_if,
  reg_native_arb_if.dn_master ds_if,
  output logic                busy
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    RESP = 2'd3
  } state_t;

  localparam int            TW    = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [TW-1:0] TLAST = (TIMEOUT > 0) ? TW'(TIMEOUT - 1) : '0;

  state_t                  state_q, state_d;
  logic                    ptr_q, ptr_d;
  logic                    gnt_q, gnt_d;
  logic                    wr_q, wr_d;
  logic                    rd_q, rd_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic                    err_q, err_d;
  logic [TW-1:0]           tcnt_q, tcnt_d;

  logic                    any_req;
  logic                    sel;
  logic                    sel_wr;
  logic                    sel_rd;
  logic [ADDR_WIDTH-1:0]   sel_addr;
  logic [DATA_WIDTH-1:0]   sel_wdata;
  logic                    timed_out;
  logic                    active;
  logic                    ack0;
  logic                    ack1;

  // The pointer only breaks ties; a lone requester is granted regardless.
  assign any_req   = m0_if.req_vld | m1_if.req_vld;
  assign sel       = (m0_if.req_vld & m1_if.req_vld) ? ptr_q : m1_if.req_vld;
  assign sel_wr    = sel ? m1_if.wr_en   : m0_if.wr_en;
  assign sel_rd    = sel ? m1_if.rd_en   : m0_if.rd_en;
  assign sel_addr  = sel ? m1_if.addr    : m0_if.addr;
  assign sel_wdata = sel ? m1_if.wr_data : m0_if.wr_data;

  // tcnt_q counts cycles elapsed since the REQ cycle, so REQ itself is cycle 0.
  assign timed_out = (TIMEOUT > 0) && (tcnt_q == TLAST);

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    gnt_d   = gnt_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    tcnt_d  = tcnt_q;

    case (state_q)
      IDLE: begin
        if (any_req) begin
          gnt_d   = sel;
          wr_d    = sel_wr;
          rd_d    = sel_rd;
          addr_d  = sel_addr;
          wdata_d = sel_wdata;
          rdata_d = '0;
          tcnt_d  = '0;
          if (sel_wr ^ sel_rd) begin
            err_d   = 1'b0;
            state_d = REQ;
          end else begin
            err_d   = 1'b1;
            state_d = RESP;
          end
        end
      end

      REQ, WAIT: begin
        if (ds_if.ack_vld) begin
          rdata_d = rd_q ? ds_if.rd_data : '0;
          err_d   = 1'b0;
          state_d = RESP;
        end else if (timed_out) begin
          rdata_d = '0;
          err_d   = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
          if (tcnt_q != '1) begin
            tcnt_d = tcnt_q + TW'(1);
          end
        end
      end

      RESP: begin
        ptr_d   = ~gnt_q;
        state_d = IDLE;
        wr_d    = 1'b0;
        rd_d    = 1'b0;
        addr_d  = '0;
        wdata_d = '0;
        rdata_d = '0;
        err_d   = 1'b0;
        tcnt_d  = '0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge fsm_clk) begin
    if (!fsm_rstn) begin
      state_q <= IDLE;
      ptr_q   <= 1'b0;
      gnt_q   <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
      tcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      gnt_q   <= gnt_d;
      wr_q    <= wr_d;
      rd_q    <= rd_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      tcnt_q  <= tcnt_d;
    end
  end

  // A malformed request latches fields but jumps straight to RESP, so gate on REQ/WAIT.
  assign active        = (state_q == REQ) || (state_q == WAIT);
  assign ds_if.req_vld = (state_q == REQ);
  assign ds_if.wr_en   = active & wr_q;
  assign ds_if.rd_en   = active & rd_q;
  assign ds_if.addr    = active ? addr_q  : '0;
  assign ds_if.wr_data = active ? wdata_q : '0;

  assign ack0 = (state_q == RESP) & ~gnt_q;
  assign ack1 = (state_q == RESP) &  gnt_q;

  assign m0_if.ack_vld = ack0;
  assign m0_if.rd_data = ack0 ? rdata_q : '0;
  assign m0_if.err     = ack0 & err_q;

  assign m1_if.ack_vld = ack1;
  assign m1_if.rd_data = ack1 ? rdata_q : '0;
  assign m1_if.err     = ack1 & err_q;

  assign busy = (state_q != IDLE);

endmodule

// File: tb/tb_reg_native_arb.sv
// Scenario bench for reg_native_arb: scoreboard of expected downstream requests and
// upstream completions, plus per-scenario latency and ordering checks.
module tb_reg_native_arb;

  localparam int AW  = 64;
  localparam int DW  = 32;
  localparam int TMO = 8;

  typedef struct {
    logic          wr;
    logic          rd;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } ds_t;

  typedef struct {
    int            id;
    logic [DW-1:0] rdata;
    logic          err;
  } up_t;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  logic busy;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;

  ds_t exp_ds[$];
  up_t exp_up[$];
  int  ack_log[$];

  int            resp_k      = 1;
  bit            resp_never  = 1'b0;
  bit            stray_ack   = 1'b0;
  logic [DW-1:0] resp_rdata  = 32'h5555_5555;
  int            resp_cnt    = 0;
  int            ds_pulses   = 0;
  bit            outstanding = 1'b0;

  always #5 clk = ~clk;

  reg_native_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u0 ();
  reg_native_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) u1 ();
  reg_native_arb_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dn ();

  assign dn.err = 1'b0;

  reg_native_arb #(
    .ADDR_WIDTH(AW),
    .DATA_WIDTH(DW),
    .TIMEOUT   (TMO)
  ) dut (
    .fsm_clk (clk),
    .fsm_rstn(rstn),
    .m0_if   (u0),
    .m1_if   (u1),
    .ds_if   (dn),
    .busy    (busy)
  );

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Downstream target model: acks resp_k cycles after req_vld unless resp_never.
  initial begin
    dn.ack_vld = 1'b0;
    dn.rd_data = '0;
    forever begin
      @(posedge clk);
      #2;
      dn.ack_vld = 1'b0;
      dn.rd_data = '0;
      if (stray_ack) begin
        dn.ack_vld = 1'b1;
        dn.rd_data = 32'hDEAD_BEEF;
        stray_ack  = 1'b0;
      end else if (dn.req_vld === 1'b1 && !resp_never) begin
        if (resp_k == 0) begin
          dn.ack_vld = 1'b1;
          dn.rd_data = resp_rdata;
        end else begin
          resp_cnt = resp_k;
        end
      end else if (resp_cnt > 0) begin
        resp_cnt--;
        if (resp_cnt == 0) begin
          dn.ack_vld = 1'b1;
          dn.rd_data = resp_rdata;
        end
      end
    end
  end

  // Scoreboard monitor, sampling mid-cycle.
  initial begin
    ds_t de;
    up_t ue;
    int            id;
    logic [DW-1:0] rd;
    logic          er;
    forever begin
      @(negedge clk);
      if (rstn) begin
        if (dn.req_vld === 1'b1) begin
          ds_pulses++;
          n_checks++;
          if (exp_ds.size() == 0) begin
            n_errors++;
            $display("FAIL ds_unexpected: req_vld addr=%h, required no request", dn.addr);
          end else begin
            de = exp_ds.pop_front();
            if (dn.wr_en !== de.wr || dn.rd_en !== de.rd || dn.addr !== de.addr || dn.wr_data !== de.wdata) begin
              n_errors++;
              $display("FAIL ds_fields: got wr=%b rd=%b addr=%h data=%h, required wr=%b rd=%b addr=%h data=%h",
                       dn.wr_en, dn.rd_en, dn.addr, dn.wr_data, de.wr, de.rd, de.addr, de.wdata);
            end
          end
          n_checks++;
          if (outstanding) begin
            n_errors++;
            $display("FAIL ds_overlap: second req_vld got while outstanding=1, required 0");
          end
          outstanding = 1'b1;
        end
        if (dn.ack_vld === 1'b1) outstanding = 1'b0;

        if (u0.ack_vld === 1'b1 || u1.ack_vld === 1'b1) begin
          n_checks++;
          if (u0.ack_vld === 1'b1 && u1.ack_vld === 1'b1) begin
            n_errors++;
            $display("FAIL up_both_ack: got both acks, required one");
          end
          id = (u1.ack_vld === 1'b1) ? 1 : 0;
          rd = id ? u1.rd_data : u0.rd_data;
          er = id ? u1.err : u0.err;
          n_checks++;
          if (exp_up.size() == 0) begin
            n_errors++;
            $display("FAIL up_unexpected: ack from m%0d, required none", id);
          end else begin
            ue = exp_up.pop_front();
            if (id !== ue.id || rd !== ue.rdata || er !== ue.err) begin
              n_errors++;
              $display("FAIL up_resp: got m%0d rd_data=%h err=%b, required m%0d rd_data=%h err=%b",
                       id, rd, er, ue.id, ue.rdata, ue.err);
            end
          end
          $display("txn cycle=%0d m%0d rd_data=%h err=%b", cyc, id, rd, er);
          ack_log.push_back(id);
          outstanding = 1'b0;
        end

        n_checks++;
        if ((u0.ack_vld !== 1'b1 && (u0.rd_data !== '0 || u0.err !== 1'b0)) ||
            (u1.ack_vld !== 1'b1 && (u1.rd_data !== '0 || u1.err !== 1'b0))) begin
          n_errors++;
          $display("FAIL up_idle_zero: got m0 %h/%b m1 %h/%b without ack, required zeros",
                   u0.rd_data, u0.err, u1.rd_data, u1.err);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int id, input logic v, input logic w, input logic r,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    if (id == 0) begin
      u0.req_vld = v; u0.wr_en = w; u0.rd_en = r; u0.addr = a; u0.wr_data = d;
    end else begin
      u1.req_vld = v; u1.wr_en = w; u1.rd_en = r; u1.addr = a; u1.wr_data = d;
    end
  endtask

  function automatic void push_ds(input logic w, input logic r, input logic [AW-1:0] a, input logic [DW-1:0] d);
    ds_t e;
    e.wr = w; e.rd = r; e.addr = a; e.wdata = d;
    exp_ds.push_back(e);
  endfunction

  function automatic void push_up(input int id, input logic [DW-1:0] rdv, input logic er);
    up_t e;
    e.id = id; e.rdata = rdv; e.err = er;
    exp_up.push_back(e);
  endfunction

  task automatic test_reset();
    rstn = 1'b0;
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    tick();
    tick();
    n_checks++;
    if ({busy, dn.req_vld, dn.wr_en, dn.rd_en} !== 4'b0) begin
      n_errors++;
      $display("FAIL reset_ctrl: got busy/req/wr/rd=%b, required 0000", {busy, dn.req_vld, dn.wr_en, dn.rd_en});
    end
    n_checks++;
    if (dn.addr !== '0 || dn.wr_data !== '0) begin
      n_errors++;
      $display("FAIL reset_bus: got addr=%h data=%h, required 0", dn.addr, dn.wr_data);
    end
    n_checks++;
    if ({u0.ack_vld, u0.err, u1.ack_vld, u1.err} !== 4'b0 || u0.rd_data !== '0 || u1.rd_data !== '0) begin
      n_errors++;
      $display("FAIL reset_up: got ack/err=%b rd0=%h rd1=%h, required 0",
               {u0.ack_vld, u0.err, u1.ack_vld, u1.err}, u0.rd_data, u1.rd_data);
    end
    rstn = 1'b1;
    tick();
    n_checks++;
    if (busy !== 1'b0) begin
      n_errors++;
      $display("FAIL reset_idle_busy: got %b, required 0", busy);
    end
  endtask

  task automatic test_write();
    int c0, p0;
    bit got;
    resp_k = 3;
    resp_rdata = 32'h5555_5555;
    p0 = ds_pulses;
    c0 = cyc;
    drive(0, 1, 1, 0, 64'h0000_0000_0000_0004, 32'h1111_1111);
    push_ds(1, 0, 64'h4, 32'h1111_1111);
    push_up(0, '0, 0);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      if (u0.ack_vld === 1'b1) got = 1;
    end
    n_checks++;
    if (!got || cyc - c0 != 5) begin
      n_errors++;
      $display("FAIL write_latency: got ack=%0d after %0d cycles, required 5", got, cyc - c0);
    end
    tick();
    drive(0, 0, 0, 0, '0, '0);
    n_checks++;
    if (u0.ack_vld !== 1'b0) begin
      n_errors++;
      $display("FAIL write_ack_width: got ack still %b, required 0", u0.ack_vld);
    end
    n_checks++;
    if (ds_pulses - p0 != 1) begin
      n_errors++;
      $display("FAIL write_pulses: got %0d req_vld pulses, required 1", ds_pulses - p0);
    end
  endtask

  task automatic test_fairness();
    int n_ack;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    outstanding = 1'b0;
    tick();
    ack_log.delete();
    resp_k = 1;
    resp_rdata = 32'h1234_5678;
    for (int k = 0; k < 2; k++) begin
      push_ds(1, 0, 64'h100, 32'hC0DE_0000);
      push_up(0, '0, 0);
      push_ds(0, 1, 64'h200, '0);
      push_up(1, 32'h1234_5678, 0);
    end
    drive(0, 1, 1, 0, 64'h100, 32'hC0DE_0000);
    drive(1, 1, 0, 1, 64'h200, '0);
    n_ack = 0;
    for (int n = 0; n < 100 && n_ack < 4; n++) begin
      tick();
      if (u0.ack_vld === 1'b1 || u1.ack_vld === 1'b1) n_ack++;
    end
    tick();
    drive(0, 0, 0, 0, '0, '0);
    drive(1, 0, 0, 0, '0, '0);
    n_checks++;
    if (n_ack != 4 || ack_log.size() != 4) begin
      n_errors++;
      $display("FAIL fair_count: got %0d acks (log %0d), required 4", n_ack, ack_log.size());
    end else begin
      for (int k = 0; k < 4; k++) begin
        n_checks++;
        if (ack_log[k] != (k % 2)) begin
          n_errors++;
          $display("FAIL fair_order: grant %0d got m%0d, required m%0d", k, ack_log[k], k % 2);
        end
      end
    end
  endtask

  task automatic test_read();
    int c0;
    bit got;
    resp_k = 0;
    resp_rdata = 32'hAAAA_AAAA;
    c0 = cyc;
    drive(1, 1, 0, 1, 64'h40, '0);
    push_ds(0, 1, 64'h40, '0);
    push_up(1, 32'hAAAA_AAAA, 0);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      if (u1.ack_vld === 1'b1) got = 1;
    end
    n_checks++;
    if (!got || cyc - c0 != 2) begin
      n_errors++;
      $display("FAIL read_latency: got ack=%0d after %0d cycles, required 2", got, cyc - c0);
    end
    n_checks++;
    if (u1.rd_data !== 32'hAAAA_AAAA || u0.ack_vld !== 1'b0 || u0.rd_data !== '0) begin
      n_errors++;
      $display("FAIL read_data: got m1 %h m0 ack=%b rd=%h, required AAAAAAAA 0 0",
               u1.rd_data, u0.ack_vld, u0.rd_data);
    end
    tick();
    drive(1, 0, 0, 0, '0, '0);
  endtask

  task automatic test_timeout();
    int c0, p0;
    bit got, bad;
    resp_never = 1'b1;
    c0 = cyc;
    drive(0, 1, 0, 1, 64'h80, '0);
    push_ds(0, 1, 64'h80, '0);
    push_up(0, '0, 1);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      if (u0.ack_vld === 1'b1) got = 1;
    end
    n_checks++;
    if (!got || cyc - c0 != TMO + 1) begin
      n_errors++;
      $display("FAIL timeout_latency: got ack=%0d after %0d cycles, required %0d", got, cyc - c0, TMO + 1);
    end
    n_checks++;
    if (u0.err !== 1'b1 || u0.rd_data !== '0) begin
      n_errors++;
      $display("FAIL timeout_err: got err=%b rd=%h, required 1 0", u0.err, u0.rd_data);
    end
    tick();
    drive(0, 0, 0, 0, '0, '0);
    p0 = ds_pulses;
    tick();
    tick();
    stray_ack = 1'b1;
    bad = 0;
    for (int n = 0; n < 4; n++) begin
      tick();
      if (busy !== 1'b0 || u0.ack_vld !== 1'b0 || u1.ack_vld !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad || ds_pulses != p0) begin
      n_errors++;
      $display("FAIL timeout_stray: got disturbance=%0d pulses=%0d, required 0 0", bad, ds_pulses - p0);
    end
    resp_never = 1'b0;
  endtask

  task automatic test_malformed();
    int c0, p0;
    bit got;
    p0 = ds_pulses;
    c0 = cyc;
    drive(0, 1, 1, 1, 64'hC, 32'h3333_3333);
    push_up(0, '0, 1);
    got = 0;
    for (int n = 0; n < 20 && !got; n++) begin
      tick();
      if (u0.ack_vld === 1'b1) got = 1;
    end
    n_checks++;
    if (!got || cyc - c0 != 1 || u0.err !== 1'b1) begin
      n_errors++;
      $display("FAIL malformed_ack: got ack=%0d after %0d cycles err=%b, required 1 cycle err=1",
               got, cyc - c0, u0.err);
    end
    tick();
    drive(0, 0, 0, 0, '0, '0);
    n_checks++;
    if (ds_pulses != p0) begin
      n_errors++;
      $display("FAIL malformed_issued: got %0d req_vld pulses, required 0", ds_pulses - p0);
    end
    resp_k = 2;
    resp_rdata = 32'h5555_5555;
    c0 = cyc;
    drive(1, 1, 1, 0, 64'h10, 32'h4444_4444);
    push_ds(1, 0, 64'h10, 32'h4444_4444);
    push_up(1, '0, 0);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      if (u1.ack_vld === 1'b1) got = 1;
    end
    n_checks++;
    if (!got || cyc - c0 != 4) begin
      n_errors++;
      $display("FAIL malformed_next: got ack=%0d after %0d cycles, required 4", got, cyc - c0);
    end
    tick();
    drive(1, 0, 0, 0, '0, '0);
  endtask

  task automatic test_reset_in_wait();
    int c0;
    bit got, bad, pend0, pend1, done0, done1;
    resp_k = 2;
    drive(0, 1, 1, 0, 64'h20, 32'h6666_6666);
    push_ds(1, 0, 64'h20, 32'h6666_6666);
    push_up(0, '0, 0);
    got = 0;
    for (int n = 0; n < 40 && !got; n++) begin
      tick();
      if (u0.ack_vld === 1'b1) got = 1;
    end
    tick();
    drive(0, 0, 0, 0, '0, '0);
    n_checks++;
    if (!got) begin
      n_errors++;
      $display("FAIL rst_setup: got no m0 ack, required ack");
    end
    resp_k = 5;
    c0 = cyc;
    drive(1, 1, 1, 0, 64'h30, 32'h7777_7777);
    push_ds(1, 0, 64'h30, 32'h7777_7777);
    tick();
    tick();
    n_checks++;
    if (busy !== 1'b1 || dn.req_vld !== 1'b0 || dn.wr_en !== 1'b1 || dn.addr !== 64'h30 || dn.wr_data !== 32'h7777_7777) begin
      n_errors++;
      $display("FAIL wait_hold: got busy=%b req=%b wr=%b addr=%h data=%h, required 1 0 1 30 77777777",
               busy, dn.req_vld, dn.wr_en, dn.addr, dn.wr_data);
    end
    tick();
    rstn = 1'b0;
    drive(1, 0, 0, 0, '0, '0);
    tick();
    rstn = 1'b1;
    outstanding = 1'b0;
    exp_up.delete();
    n_checks++;
    if ({busy, dn.req_vld, dn.wr_en, dn.rd_en, u0.ack_vld, u1.ack_vld, u0.err, u1.err} !== 8'b0 ||
        dn.addr !== '0 || dn.wr_data !== '0 || u0.rd_data !== '0 || u1.rd_data !== '0) begin
      n_errors++;
      $display("FAIL rst_outputs: got ctrl=%b addr=%h data=%h, required all 0",
               {busy, dn.req_vld, dn.wr_en, dn.rd_en, u0.ack_vld, u1.ack_vld, u0.err, u1.err},
               dn.addr, dn.wr_data);
    end
    bad = 0;
    for (int n = 0; n < 5; n++) begin
      tick();
      if (busy !== 1'b0 || u0.ack_vld !== 1'b0 || u1.ack_vld !== 1'b0) bad = 1;
    end
    n_checks++;
    if (bad) begin
      n_errors++;
      $display("FAIL rst_late_ack: got activity after late ack at cycle %0d, required none", c0 + 6);
    end
    resp_k = 1;
    resp_rdata = 32'h9999_0000;
    ack_log.delete();
    push_ds(0, 1, 64'h50, '0);
    push_up(0, 32'h9999_0000, 0);
    push_ds(1, 0, 64'h60, 32'h8888_8888);
    push_up(1, '0, 0);
    drive(0, 1, 0, 1, 64'h50, '0);
    drive(1, 1, 1, 0, 64'h60, 32'h8888_8888);
    pend0 = 0; pend1 = 0; done0 = 0; done1 = 0;
    for (int n = 0; n < 60 && !(done0 && done1); n++) begin
      tick();
      if (pend0) begin drive(0, 0, 0, 0, '0, '0); pend0 = 0; done0 = 1; end
      if (pend1) begin drive(1, 0, 0, 0, '0, '0); pend1 = 0; done1 = 1; end
      if (u0.ack_vld === 1'b1 && !done0) pend0 = 1;
      if (u1.ack_vld === 1'b1 && !done1) pend1 = 1;
    end
    n_checks++;
    if (!(done0 && done1) || ack_log.size() != 2) begin
      n_errors++;
      $display("FAIL rst_after: got done0=%0d done1=%0d acks=%0d, required 1 1 2", done0, done1, ack_log.size());
    end else begin
      n_checks++;
      if (ack_log[0] != 0 || ack_log[1] != 1) begin
        n_errors++;
        $display("FAIL rst_pointer: got order m%0d,m%0d, required m0,m1", ack_log[0], ack_log[1]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_write();
    test_fairness();
    test_read();
    test_timeout();
    test_malformed();
    test_reset_in_wait();
    tick();
    tick();
    n_checks++;
    if (exp_ds.size() != 0 || exp_up.size() != 0) begin
      n_errors++;
      $display("FAIL scoreboard_drain: got %0d ds and %0d up pending, required 0 0", exp_ds.size(), exp_up.size());
    end
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
